// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Definitions shared by the UART transmitter and receiver: default frame
//   geometry, the oversampling factor of the common baud-rate generator and
//   the FSM state encoding.
//
//   Contents
//     UART_NBIT_DATA      data bits per frame
//     UART_NUM_TICKS      baud ticks per serial bit (same value on RX and TX)
//     IDLE/START/DATA/STOP  2-bit FSM state constants (00/01/10/11)
//     frame_ticks()       ticks spanned by one complete frame
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam int UART_NBIT_DATA = 8;
  localparam int UART_NUM_TICKS = 16;

  // The state encoding is shared with the receiver, so it stays as plain
  // 2-bit constants rather than an enum.
  typedef logic [1:0] uart_state_t;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  // Start bit + data bits + one stop bit, each NUM_TICKS ticks long.
  function automatic int frame_ticks(input int nbit_data, input int num_ticks);
    return (nbit_data + 2) * num_ticks;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Host-side handshake of the UART transmitter.
//
//   Signals
//     tx_start      host -> tx   request to send data_in (honoured only when idle)
//     data_in       host -> tx   word to send, captured on the accepting edge
//     tx_busy       tx -> host   high from accept until the frame completes
//     tx_done_tick  tx -> host   one-clock pulse when the stop bit completes
//
//   Modports
//     master  host / bus side
//     slave   transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_if
  import uart_tx_pkg::*;
#(
  parameter int NBIT_DATA = UART_NBIT_DATA
);

  logic                 tx_start;
  logic [NBIT_DATA-1:0] data_in;
  logic                 tx_busy;
  logic                 tx_done_tick;

  modport master (
    output tx_start,
    output data_in,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  data_in,
    output tx_busy,
    output tx_done_tick
  );

endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Serialises one NBIT_DATA word per request as a start
//   bit (0), NBIT_DATA data bits LSB first, and one stop bit (1). Bit timing
//   comes from the shared baud-rate generator: every serial bit lasts exactly
//   NUM_TICKS tick pulses, counted from the first tick after the bit began.
//
//   Ports
//     clk      in   system clock, all state changes on posedge
//     reset    in   asynchronous, active-high reset
//     tick     in   baud-rate enable, one-clock pulse, NUM_TICKS per bit
//     host     if   uart_tx_if.slave: tx_start, data_in, tx_busy, tx_done_tick
//     tx_bit   out  registered serial line; idle/stop = 1, start = 0
//
//   Parameters
//     NBIT_DATA      data bits per frame
//     LEN_DATA       width of the data-bit counter
//     NUM_TICKS      baud ticks per serial bit
//     LEN_NUM_TICKS  width of the tick counter
// -----------------------------------------------------------------------------
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int NBIT_DATA     = UART_NBIT_DATA,
  parameter int LEN_DATA      = $clog2(NBIT_DATA),
  parameter int NUM_TICKS     = UART_NUM_TICKS,
  parameter int LEN_NUM_TICKS = $clog2(NUM_TICKS)
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  uart_tx_if.slave host,
  output logic     tx_bit
);

  localparam logic [LEN_NUM_TICKS-1:0] TICK_LAST = LEN_NUM_TICKS'(NUM_TICKS - 1);
  localparam logic [LEN_DATA-1:0]      BIT_LAST  = LEN_DATA'(NBIT_DATA - 1);

  uart_state_t              state;
  logic [LEN_NUM_TICKS-1:0] tick_cnt;
  logic [LEN_DATA-1:0]      bit_cnt;
  logic [NBIT_DATA-1:0]     shift_reg;
  logic                     done_r;

  // A bit period ends on the tick that finds the counter at its last value.
  logic bit_end;
  assign bit_end = tick && (tick_cnt == TICK_LAST);

  assign host.tx_busy      = (state != IDLE);
  assign host.tx_done_tick = done_r;

  // Single registered FSM. tx_bit is always written from this block so the
  // serial line never glitches on state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_bit    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      // The done strobe is a single-cycle pulse; it is re-asserted only on
      // the edge that closes the stop bit.
      done_r <= 1'b0;

      case (state)
        IDLE: begin
          tx_bit <= 1'b1;
          // Acceptance does not wait for a tick: the line drops one clock
          // after the request.
          if (host.tx_start) begin
            shift_reg <= host.data_in;
            tick_cnt  <= '0;
            tx_bit    <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_bit   <= shift_reg[0];
            state    <= DATA;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            tick_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[NBIT_DATA-1:1]};
            if (bit_cnt == BIT_LAST) begin
              tx_bit <= 1'b1;
              state  <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // shift_reg[1] is the LSB after this edge's shift.
              tx_bit  <= shift_reg[1];
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOP: begin
          tx_bit <= 1'b1;
          if (bit_end) begin
            tick_cnt <= '0;
            done_r   <= 1'b1;
            state    <= IDLE;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          tx_bit <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int NB          = UART_NBIT_DATA;
  localparam int NT          = UART_NUM_TICKS;
  localparam int FRAME_BITS  = NB + 2;
  localparam int FRAME_TICKS = FRAME_BITS * NT;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic tx_bit;

  uart_tx_if #(.NBIT_DATA(NB)) u_if ();

  uart_tx #(.NBIT_DATA(NB), .NUM_TICKS(NT)) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .host   (u_if),
    .tx_bit (tx_bit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation state filled by the monitor process.
  bit line_q[$];     // line value seen just before every tick edge while busy
  int done_cnt  = 0;
  int last_gap  = -1;
  int idle_run  = 0;
  bit prev_busy = 1'b0;
  int tick_div  = 4;
  bit tick_en   = 1'b1;
  int phase     = 0;

  // Tick generator and monitor. Outputs are sampled on the falling edge;
  // tick is decided here for the next rising edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.tx_done_tick === 1'b1) done_cnt++;
      if (u_if.tx_busy === 1'b1) begin
        if (!prev_busy) last_gap = idle_run;
        idle_run  = 0;
        prev_busy = 1'b1;
      end else begin
        idle_run++;
        prev_busy = 1'b0;
      end
      phase++;
      tick = tick_en && ((phase % tick_div) == 0);
      if (tick && (u_if.tx_busy === 1'b1)) line_q.push_back(tx_bit);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a frame is start(0), data LSB first, stop(1); sample j
  // of a frame falls inside serial bit j/NT.
  function automatic bit exp_line(input logic [NB-1:0] w, input int j);
    logic [FRAME_BITS-1:0] frame;
    frame = {1'b1, w, 1'b0};
    return frame[j / NT];
  endfunction

  function automatic bit frame_ok(input int base, input logic [NB-1:0] w);
    if (line_q.size() < base + FRAME_TICKS) return 1'b0;
    for (int j = 0; j < FRAME_TICKS; j++)
      if (line_q[base + j] != exp_line(w, j)) return 1'b0;
    return 1'b1;
  endfunction

  // Receiver-style decode: take each data bit at its mid-point.
  function automatic logic [NB-1:0] decode_word(input int base);
    logic [NB-1:0] w;
    w = '0;
    for (int b = 0; b < NB; b++)
      if (line_q.size() > base + (b + 1) * NT + NT / 2)
        w[b] = line_q[base + (b + 1) * NT + NT / 2];
    return w;
  endfunction

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_samples(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (line_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_frame(input logic [NB-1:0] w);
    @(negedge clk);
    u_if.data_in  = w;
    u_if.tx_start = 1'b1;
    @(negedge clk);
    u_if.tx_start = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    u_if.tx_start = 1'b0;
    u_if.data_in  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_bit !== 1'b1) begin errors++; $display("FAIL reset_tx_bit: got %b want 1", tx_bit); end
    checks++;
    if (u_if.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", u_if.tx_busy); end
    checks++;
    if (u_if.tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", u_if.tx_done_tick); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    bit ok;
    int d0;
    bit exp_seq[FRAME_BITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    tick_div = 4;
    line_q.delete();
    d0 = done_cnt;
    start_frame(8'hA5);
    wait_done(d0 + 1, FRAME_TICKS * 4 + 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout: done_cnt %0d want %0d", done_cnt, d0 + 1); end
    checks++;
    if (line_q.size() != FRAME_TICKS) begin errors++; $display("FAIL single_ticks: got %0d want %0d", line_q.size(), FRAME_TICKS); end
    for (int b = 0; b < FRAME_BITS; b++) begin
      checks++;
      if (line_q.size() <= b * NT || line_q[b * NT] != exp_seq[b]) begin
        errors++;
        $display("FAIL single_bit%0d: got %b want %b", b, (line_q.size() > b * NT) ? line_q[b * NT] : 1'bx, exp_seq[b]);
      end
    end
    checks++;
    if (!frame_ok(0, 8'hA5)) begin errors++; $display("FAIL single_frame_shape: decoded %h want a5", decode_word(0)); end
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL single_done_count: got %0d want %0d", done_cnt - d0, 1); end
    checks++;
    if (tx_bit !== 1'b1 || u_if.tx_busy !== 1'b0) begin
      errors++; $display("FAIL single_idle_after: tx_bit %b busy %b want 1 0", tx_bit, u_if.tx_busy);
    end
  endtask

  task automatic test_busy_reject();
    bit ok;
    int d0;
    tick_div = 4;
    line_q.delete();
    d0 = done_cnt;
    start_frame(8'h3C);
    wait_samples(50, FRAME_TICKS * 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reject_reach_tick50: got %0d ticks want 50", line_q.size()); end
    u_if.data_in  = 8'hFF;
    u_if.tx_start = 1'b1;
    @(negedge clk);
    u_if.tx_start = 1'b0;
    wait_done(d0 + 1, FRAME_TICKS * 4 + 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reject_done_timeout: done_cnt %0d want %0d", done_cnt, d0 + 1); end
    checks++;
    if (!frame_ok(0, 8'h3C)) begin errors++; $display("FAIL reject_frame: decoded %h want 3c", decode_word(0)); end
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1 || u_if.tx_busy !== 1'b0) begin
      errors++; $display("FAIL reject_second_frame: frames %0d busy %b want 1 0", done_cnt - d0, u_if.tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0;
    tick_div = 4;
    line_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    u_if.data_in  = 8'h00;
    u_if.tx_start = 1'b1;
    @(negedge clk);
    u_if.data_in  = 8'hFF;
    wait_done(d0 + 1, FRAME_TICKS * 4 + 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_timeout: done_cnt %0d want %0d", done_cnt, d0 + 1); end
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (u_if.tx_busy === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    u_if.tx_start = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_accept: busy %b want 1", u_if.tx_busy); end
    checks++;
    if (last_gap != 1) begin errors++; $display("FAIL b2b_gap: got %0d clk want 1", last_gap); end
    wait_done(d0 + 2, FRAME_TICKS * 4 + 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_timeout: done_cnt %0d want %0d", done_cnt, d0 + 2); end
    checks++;
    if (line_q.size() != 2 * FRAME_TICKS) begin errors++; $display("FAIL b2b_ticks: got %0d want %0d", line_q.size(), 2 * FRAME_TICKS); end
    checks++;
    if (!frame_ok(0, 8'h00)) begin errors++; $display("FAIL b2b_frame0: decoded %h want 00", decode_word(0)); end
    checks++;
    if (!frame_ok(FRAME_TICKS, 8'hFF)) begin errors++; $display("FAIL b2b_frame1: decoded %h want ff", decode_word(FRAME_TICKS)); end
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_tick_stall();
    bit ok;
    int d0, changes, busy_drop, frozen_size;
    logic held;
    logic [NB-1:0] w;
    tick_div = 4;
    w = NB'($urandom);
    line_q.delete();
    d0 = done_cnt;
    start_frame(w);
    wait_samples(NT * 4 + 3, FRAME_TICKS * 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_reach_data: got %0d ticks", line_q.size()); end
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    held        = tx_bit;
    frozen_size = line_q.size();
    changes     = 0;
    busy_drop   = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_bit !== held) changes++;
      if (u_if.tx_busy !== 1'b1) busy_drop++;
    end
    checks++;
    if (changes != 0 || busy_drop != 0) begin
      errors++; $display("FAIL stall_frozen: line changes %0d busy drops %0d want 0 0", changes, busy_drop);
    end
    checks++;
    if (line_q.size() != frozen_size) begin errors++; $display("FAIL stall_no_ticks: got %0d want %0d", line_q.size(), frozen_size); end
    tick_en = 1'b1;
    wait_done(d0 + 1, FRAME_TICKS * 4 + 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done_timeout: done_cnt %0d want %0d", done_cnt, d0 + 1); end
    checks++;
    if (line_q.size() != FRAME_TICKS || !frame_ok(0, w)) begin
      errors++; $display("FAIL stall_frame: ticks %0d decoded %h want %0d %h", line_q.size(), decode_word(0), FRAME_TICKS, w);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int d0, highs_lost;
    tick_div = 4;
    line_q.delete();
    start_frame(NB'($urandom));
    wait_samples(NT * 3 + 5, FRAME_TICKS * 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_reach_data: got %0d ticks", line_q.size()); end
    d0 = done_cnt;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_bit !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: tx_bit %b busy %b done %b want 1 0 0", tx_bit, u_if.tx_busy, u_if.tx_done_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    highs_lost = 0;
    repeat (FRAME_TICKS * 4) begin
      @(negedge clk);
      if (tx_bit !== 1'b1 || u_if.tx_busy !== 1'b0) highs_lost++;
    end
    checks++;
    if (highs_lost != 0) begin errors++; $display("FAIL midreset_line_idle: bad cycles %0d want 0", highs_lost); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL midreset_no_done: pulses %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_loopback();
    bit ok;
    int d0;
    logic [NB-1:0] w, got;
    tick_div = 1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      w = NB'($urandom);
      line_q.delete();
      d0 = done_cnt;
      start_frame(w);
      wait_done(d0 + 1, FRAME_TICKS + 50, ok);
      repeat (3) @(negedge clk);
      got = decode_word(0);
      checks++;
      if (!ok || got !== w) begin
        errors++; $display("FAIL loopback_word%0d: got %h want %h", k, got, w);
      end
      checks++;
      if (done_cnt != d0 + 1 || line_q.size() != FRAME_TICKS) begin
        errors++; $display("FAIL loopback_done%0d: pulses %0d ticks %0d want 1 %0d", k, done_cnt - d0, line_q.size(), FRAME_TICKS);
      end
    end
    tick_div = 4;
  endtask

  initial begin
    reset         = 1'b1;
    u_if.tx_start = 1'b0;
    u_if.data_in  = '0;
    test_reset();
    test_single_frame();
    test_busy_reject();
    test_back_to_back();
    test_tick_stall();
    test_reset_mid_frame();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
